// File: rtl/pid_sat.sv
// Fixed-point PID controller with output clamping, conditional-integration
// anti-windup, integrator clear and first-sample derivative-kick suppression.
module pid_sat #(
  parameter int W    = 16,
  parameter int GW   = 16,
  parameter int FRAC = 8,
  parameter int ACCW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  setpoint,
  input  logic [W-1:0]  meas,
  input  logic [GW-1:0] kp,
  input  logic [GW-1:0] ki,
  input  logic [GW-1:0] kd,
  input  logic [W-1:0]  out_min,
  input  logic [W-1:0]  out_max,
  input  logic          int_clear,
  output logic [W-1:0]  out,
  output logic          out_valid,
  output logic          sat
);

  localparam int EW = W + 1;
  localparam int DW = W + 2;
  localparam int PW = GW + W + 2;
  localparam int SW = ((ACCW > PW) ? ACCW : PW) + 1;
  localparam int TW = SW + 2;

  localparam logic signed [SW-1:0] ACC_MAX = {{(SW-ACCW+1){1'b0}}, {(ACCW-1){1'b1}}};
  localparam logic signed [SW-1:0] ACC_MIN = {{(SW-ACCW+1){1'b1}}, {(ACCW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_OUT} state_t;

  state_t state, state_next;

  logic [GW-1:0]          kp_reg, ki_reg, kd_reg;
  logic [W-1:0]           out_min_reg, out_max_reg;
  logic signed [EW-1:0]   e_reg, e_prev;
  logic signed [DW-1:0]   de_reg;
  logic                   first;
  logic signed [ACCW-1:0] acc;
  logic signed [PW-1:0]   p_reg, d_reg, kie_reg;
  logic signed [ACCW-1:0] icand_reg;

  logic                   accept;
  logic signed [EW-1:0]   e_now;
  logic signed [DW-1:0]   de_now;
  logic signed [PW-1:0]   p_full, d_full, kie_full;
  logic signed [SW-1:0]   isum;
  logic signed [ACCW-1:0] icand;
  logic signed [TW-1:0]   sum_t, y_t, y1, max_t, min_t;
  logic                   hi, lo, hold_acc;
  logic [W-1:0]           y2;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = S_MUL;
      end
      S_MUL:   state_next = S_OUT;
      S_OUT:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  // ---------------- accept stage ----------------
  assign e_now = $signed({setpoint[W-1], setpoint}) - $signed({meas[W-1], meas});

  // A clear on the accept edge also suppresses the derivative for this sample.
  assign de_now = (first || int_clear) ? '0
                : $signed({e_now[EW-1], e_now}) - $signed({e_prev[EW-1], e_prev});

  // ---------------- multiply stage ----------------
  assign p_full   = $signed({{(W+2){1'b0}}, kp_reg}) * $signed({{(GW+1){e_reg[EW-1]}}, e_reg});
  assign kie_full = $signed({{(W+2){1'b0}}, ki_reg}) * $signed({{(GW+1){e_reg[EW-1]}}, e_reg});
  assign d_full   = $signed({{(W+2){1'b0}}, kd_reg}) * $signed({{GW{de_reg[DW-1]}}, de_reg});

  assign isum = $signed({{(SW-ACCW){acc[ACCW-1]}}, acc})
              + $signed({{(SW-PW){kie_full[PW-1]}}, kie_full});

  always_comb begin
    icand = isum[ACCW-1:0];
    if (isum > ACC_MAX)      icand = ACC_MAX[ACCW-1:0];
    else if (isum < ACC_MIN) icand = ACC_MIN[ACCW-1:0];
  end

  // ---------------- output stage ----------------
  assign sum_t = $signed({{(TW-PW){p_reg[PW-1]}}, p_reg})
               + $signed({{(TW-ACCW){icand_reg[ACCW-1]}}, icand_reg})
               + $signed({{(TW-PW){d_reg[PW-1]}}, d_reg});
  assign y_t   = sum_t >>> FRAC;
  assign max_t = $signed({{(TW-W){out_max_reg[W-1]}}, out_max_reg});
  assign min_t = $signed({{(TW-W){out_min_reg[W-1]}}, out_min_reg});

  // Upper clamp first, then lower, so out_min wins on inverted limits.
  assign hi = (y_t > max_t);
  assign y1 = hi ? max_t : y_t;
  assign lo = (y1 < min_t);
  assign y2 = lo ? out_min_reg : y1[W-1:0];

  // Freeze the integrator only while the new integral term pushes further into the limit.
  assign hold_acc = (hi && !kie_reg[PW-1] && (|kie_reg)) || (lo && kie_reg[PW-1]);

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kp_reg      <= '0;
      ki_reg      <= '0;
      kd_reg      <= '0;
      out_min_reg <= '0;
      out_max_reg <= '0;
      e_reg       <= '0;
      de_reg      <= '0;
      e_prev      <= '0;
      first       <= 1'b1;
      acc         <= '0;
      p_reg       <= '0;
      d_reg       <= '0;
      kie_reg     <= '0;
      icand_reg   <= '0;
      out         <= '0;
      out_valid   <= 1'b0;
      sat         <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            kp_reg      <= kp;
            ki_reg      <= ki;
            kd_reg      <= kd;
            out_min_reg <= out_min;
            out_max_reg <= out_max;
            e_reg       <= e_now;
            de_reg      <= de_now;
            e_prev      <= e_now;
            first       <= 1'b0;
          end
        end
        S_MUL: begin
          p_reg     <= p_full;
          d_reg     <= d_full;
          kie_reg   <= kie_full;
          icand_reg <= icand;
        end
        S_OUT: begin
          out       <= y2;
          sat       <= hi || lo;
          out_valid <= 1'b1;
          if (!hold_acc) acc <= icand_reg;
        end
        default: ;
      endcase
      // Clear overrides any history or integrator update on the same edge.
      if (int_clear) begin
        acc    <= '0;
        e_prev <= '0;
        first  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pid_sat.sv
// Directed, table-driven bench for pid_sat with hand-computed expectations.
module tb_pid_sat;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] setpoint = '0, meas = '0;
  logic [15:0] kp = '0, ki = '0, kd = '0;
  logic [15:0] out_min = '0, out_max = '0;
  logic        int_clear = 1'b0;
  logic [15:0] out;
  logic        out_valid;
  logic        sat;

  int n_cmp = 0;
  int n_bad = 0;

  pid_sat #(.W(16), .GW(16), .FRAC(8), .ACCW(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .setpoint(setpoint), .meas(meas), .kp(kp), .ki(ki), .kd(kd),
    .out_min(out_min), .out_max(out_max), .int_clear(int_clear),
    .out(out), .out_valid(out_valid), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst;
    bit clr;
    int sp, ms, kp, ki, kd, mn, mx;
    int eo, es;
  } rec_t;

  rec_t vec[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic rec_t mk(input bit rst, input bit clr, input int sp, input int ms,
                              input int p, input int i, input int d, input int mn,
                              input int mx, input int eo, input int es);
    rec_t r;
    r.rst = rst; r.clr = clr; r.sp = sp; r.ms = ms;
    r.kp = p; r.ki = i; r.kd = d; r.mn = mn; r.mx = mx;
    r.eo = eo; r.es = es;
    return r;
  endfunction

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); int_clear = 1'b1;
    @(negedge clk); int_clear = 1'b0;
  endtask

  task automatic run_vec(input rec_t r, input int idx);
    int  cyc;
    bit  got;
    int  busy_ok;
    if (r.rst) pulse_reset();
    if (r.clr) pulse_clear();
    @(negedge clk);
    setpoint = r.sp[15:0]; meas = r.ms[15:0];
    kp = r.kp[15:0]; ki = r.ki[15:0]; kd = r.kd[15:0];
    out_min = r.mn[15:0]; out_max = r.mx[15:0];
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 0; got = 0; busy_ok = 1;
    while (!got && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (out_valid) got = 1;
      else if (in_ready) busy_ok = 0;
    end
    chk($sformatf("v%0d latency", idx), got ? cyc : -1, 3);
    chk($sformatf("v%0d busy_in_ready_low", idx), busy_ok, 1);
    chk($sformatf("v%0d out", idx), int'($signed(out)), r.eo);
    chk($sformatf("v%0d sat", idx), int'(sat), r.es);
    $display("vec %0d: sp=%0d meas=%0d kp=%0d ki=%0d kd=%0d lim=[%0d,%0d] -> out=%0d sat=%0d (exp %0d/%0d)",
             idx, r.sp, r.ms, r.kp, r.ki, r.kd, r.mn, r.mx, $signed(out), sat, r.eo, r.es);
    @(negedge clk);
    chk($sformatf("v%0d strobe_one_cycle", idx), int'(out_valid), 0);
    chk($sformatf("v%0d ready_after", idx), int'(in_ready), 1);
  endtask

  initial begin
    int cnt;
    int last_out;

    // P only, basic case
    vec.push_back(mk(1, 0, 100, 40, 256, 0, 0, -32767, 32767, 60, 0));
    // I only, accumulation then clear
    vec.push_back(mk(1, 0, 10, 0, 0, 128, 0, -32767, 32767, 5, 0));
    vec.push_back(mk(0, 0, 10, 0, 0, 128, 0, -32767, 32767, 10, 0));
    vec.push_back(mk(0, 0, 10, 0, 0, 128, 0, -32767, 32767, 15, 0));
    vec.push_back(mk(0, 0, 10, 0, 0, 128, 0, -32767, 32767, 20, 0));
    vec.push_back(mk(0, 1, 10, 0, 0, 128, 0, -32767, 32767, 5, 0));
    // anti-windup at upper limit
    vec.push_back(mk(1, 0, 100, 0, 0, 256, 0, -32767, 250, 100, 0));
    vec.push_back(mk(0, 0, 100, 0, 0, 256, 0, -32767, 250, 200, 0));
    vec.push_back(mk(0, 0, 100, 0, 0, 256, 0, -32767, 250, 250, 1));
    vec.push_back(mk(0, 0, 100, 0, 0, 256, 0, -32767, 250, 250, 1));
    vec.push_back(mk(0, 0, -50, 0, 0, 256, 0, -32767, 250, 150, 0));
    // derivative, first-sample suppression
    vec.push_back(mk(1, 0, 20, 0, 0, 0, 256, -32767, 32767, 0, 0));
    vec.push_back(mk(0, 0, 30, 0, 0, 0, 256, -32767, 32767, 10, 0));
    vec.push_back(mk(0, 0, 30, 0, 0, 0, 256, -32767, 32767, 0, 0));
    // lower clamp, inverted limits
    vec.push_back(mk(1, 0, -500, 0, 256, 0, 0, -100, 32767, -100, 1));
    vec.push_back(mk(0, 0, 0, 0, 256, 0, 0, 50, 10, 50, 1));
    // floor of negative fractional result: 128*-3 = -384 -> -1.5 -> -2
    vec.push_back(mk(1, 0, -3, 0, 128, 0, 0, -32767, 32767, -2, 0));
    // widest error: 32767 - (-32768) = 65535, clamped high
    vec.push_back(mk(1, 0, 32767, -32768, 256, 0, 0, -32768, 32767, 32767, 1));

    #2 reset = 1'b1;
    @(negedge clk);
    chk("reset out", int'(out), 0);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset sat", int'(sat), 0);
    chk("reset in_ready", int'(in_ready), 1);
    reset = 1'b0;

    for (int i = 0; i < vec.size(); i++) run_vec(vec[i], i);

    // in_valid held through MUL/OUT with gain/input changes: exactly one output, from the latched sample
    pulse_reset();
    @(negedge clk);
    setpoint = 16'd100; meas = 16'd40; kp = 16'd256; ki = '0; kd = '0;
    out_min = 16'h8001; out_max = 16'h7fff;
    in_valid = 1'b1;
    @(posedge clk);
    cnt = 0; last_out = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin kp = 16'd0; setpoint = 16'd0; end
      if (out_valid) begin cnt++; last_out = int'($signed(out)); end
      if (i == 2) in_valid = 1'b0;
    end
    chk("held_valid count", cnt, 1);
    chk("held_valid out", last_out, 60);
    $display("held in_valid: outputs=%0d out=%0d", cnt, last_out);

    // reset one cycle after accept aborts the sample
    @(negedge clk);
    setpoint = 16'd200; meas = 16'd0; kp = 16'd256;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("abort out_valid count", cnt, 0);
    chk("abort out", int'(out), 0);
    chk("abort in_ready", int'(in_ready), 1);
    $display("reset abort: outputs=%0d out=%0d in_ready=%0d", cnt, out, in_ready);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
